// File: rtl/node_request_controller_pkg.sv
// Shared definitions for the node request controller and the path-capture block.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package node_request_controller_pkg;

   // Controller sequencing states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   // CPU read-map addresses
   localparam logic [31:0] START_ADDR_C  = 32'h0200_0000;
   localparam logic [31:0] END_ADDR_C    = 32'h0200_0004;
   localparam logic [31:0] STATUS_ADDR_C = 32'h0200_0010;

endpackage

// File: rtl/node_req_fifo.sv
// Request queue holding packed {start, end} node pairs, DEPTH entries deep.
// Latency: head is visible the cycle after the push edge; pop takes effect on the edge.
// Backpressure: full flag blocks further pushes; pop on empty is ignored.
module node_req_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Storage array: written on accepted push, never reset
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/node_request_controller.sv
// Queues start/end node requests and sequences the CPU through one path search per request.
// Latency: CPU leaves reset 2 cycles after the queue becomes non-empty in IDLE.
// Backpressure: req_ready drops while the request FIFO is full.
module node_request_controller
   import node_request_controller_pkg::*;
#(
   parameter int          NODE_W      = 5,
   parameter int          DEPTH       = 4,
   parameter int          TIMEOUT     = 1_000_000,
   parameter logic [31:0] START_ADDR  = START_ADDR_C,
   parameter logic [31:0] END_ADDR    = END_ADDR_C,
   parameter logic [31:0] STATUS_ADDR = STATUS_ADDR_C
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic [NODE_W-1:0] req_start,
   input  logic [NODE_W-1:0] req_end,
   output logic              req_ready,
   input  logic [31:0]       DataAdr,
   output logic [31:0]       ReadData,
   output logic              rd_hit,
   input  logic              path_found,
   output logic              cpu_reset,
   output logic              path_ack,
   output logic              timeout_err
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   state_t              state;
   state_t              state_next;
   logic [2*NODE_W-1:0] fifo_head;
   logic                fifo_full;
   logic                fifo_empty;
   logic                push;
   logic                pop;
   logic [NODE_W-1:0]   cur_start;
   logic [NODE_W-1:0]   cur_end;
   logic [WD_W-1:0]     watchdog;
   logic                path_prev;
   logic                path_edge;
   logic                wd_expire;

   assign req_ready = !fifo_full;
   assign push      = req_valid && req_ready;
   assign pop       = (state == LOAD);
   assign path_edge = path_found && !path_prev;
   assign wd_expire = (watchdog == WD_W'(TIMEOUT - 1));

   node_req_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (2*NODE_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data ({req_start, req_end}),
      .pop       (pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state and CPU control outputs; the CPU runs only in RUN
   always_comb begin
      state_next = state;
      cpu_reset  = 1'b1;
      path_ack   = 1'b0;
      case (state)
         IDLE: if (!fifo_empty) state_next = LOAD;
         LOAD: state_next = RUN;
         RUN: begin
            cpu_reset = 1'b0;
            if (path_edge || wd_expire) state_next = DONE;
         end
         DONE: begin
            path_ack   = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Request latch, watchdog and completion-edge tracking; a completion edge beats expiry
   always_ff @(posedge clk) begin
      if (reset) begin
         cur_start   <= '0;
         cur_end     <= '0;
         watchdog    <= '0;
         timeout_err <= 1'b0;
         path_prev   <= 1'b0;
      end else begin
         path_prev <= path_found;
         if (state == LOAD) begin
            cur_start   <= fifo_head[2*NODE_W-1:NODE_W];
            cur_end     <= fifo_head[NODE_W-1:0];
            timeout_err <= 1'b0;
            watchdog    <= '0;
         end else if (state == RUN) begin
            watchdog <= watchdog + WD_W'(1);
            if (wd_expire && !path_edge) timeout_err <= 1'b1;
         end
      end
   end

   // CPU read map, purely combinational from the address
   always_comb begin
      ReadData = '0;
      rd_hit   = 1'b0;
      if (DataAdr == START_ADDR) begin
         rd_hit                = 1'b1;
         ReadData[NODE_W-1:0]  = cur_start;
      end else if (DataAdr == END_ADDR) begin
         rd_hit                = 1'b1;
         ReadData[NODE_W-1:0]  = cur_end;
      end else if (DataAdr == STATUS_ADDR) begin
         rd_hit                = 1'b1;
         ReadData[2:0]         = {timeout_err, !fifo_empty, state == RUN};
      end
   end

endmodule
